core_boot_ctrl: RTL and testbench
=================================

Name: core_boot_ctrl

Overview:
Boot/run sequencer for the RV32I core. Holds the core in reset, streams a program byte-by-byte into instruction memory, releases the core, and counts run cycles. Stops the run on a core halt request or a cycle limit. Sits between the host byte link, insn_memory's write port and the core's reset/enable inputs.

Parameters:
ADDR_W, 10, instruction memory word-address width (1024 words)
CNT_W, 16, width of the cycle counter and run_limit

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-low reset
load_start  input  1  pulse: begin a load (accepted in IDLE or HALT only)
load_len  input  ADDR_W+1  words to load; 0 = run existing program; values >1024 clipped to 1024
run_limit  input  CNT_W  max RUN cycles; 0 = unlimited
rx_data  input  8  program byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  byte accepted on the clock edge where rx_valid & rx_ready
halt_req  input  1  core decoded ECALL/EBREAK
mem_we  output  1  insn memory write strobe
mem_addr  output  ADDR_W  insn memory word address
mem_wdata  output  32  insn memory write data
core_reset_n  output  1  active-low reset to core
core_en  output  1  core step enable (state frozen when 0)
busy  output  1  high in LOAD, WRITE, RELEASE, RUN
done  output  1  one-cycle pulse on entry to HALT
status  output  2  00 none, 01 halted by halt_req, 10 limit reached
cycle_count  output  CNT_W  RUN cycles elapsed

Behaviour:
- Reset (async, reset=0): state IDLE; rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_reset_n=0, core_en=0, busy=0, done=0, status=00, cycle_count=0. Partial word and byte index discarded. Reset mid-load or mid-run gives the same result.
- States: IDLE, LOAD, WRITE, RELEASE, RUN, HALT.
- IDLE/HALT + load_start:
  - load_len=0 → RELEASE.
  - Otherwise → LOAD; word index=0, byte index=0, status=00. load_len and run_limit are latched at this edge.
- LOAD:
  - rx_ready=1. Each accepted byte is placed little-endian: byte 0 → bits 7:0 … byte 3 → bits 31:24.
  - On acceptance of byte 3 → WRITE.
  - rx_valid low stalls indefinitely.
- WRITE (exactly 1 cycle):
  - rx_ready=0, mem_we=1, mem_addr=word index, mem_wdata=assembled word. mem_we is high in the cycle after byte 3 is accepted.
  - Next: word index+1. If words written == latched load_len → RELEASE, else → LOAD.
  - Word index wraps within 0..1023 (unreachable after clipping).
- RELEASE (1 cycle): core_reset_n=0, cycle_count←0 → RUN.
- RUN:
  - core_reset_n=1, core_en=1; cycle_count increments every cycle and includes the cycle in which halt_req is sampled.
  - halt_req=1 → HALT, status=01.
  - If run_limit≠0 and cycle_count+1 == run_limit → HALT, status=10, so RUN lasts exactly run_limit cycles.
  - halt_req and limit in the same cycle → status=01.
  - run_limit=0: counter saturates at all-ones and never halts by limit.
- HALT:
  - core_reset_n=1, core_en=0 (register file preserved for inspection). done=1 only in the first HALT cycle.
  - status and cycle_count are held until the next load_start.
- load_start in LOAD/WRITE/RELEASE/RUN is ignored.
- core_reset_n=0 in IDLE, LOAD, WRITE, RELEASE. mem_we=0 outside WRITE.
- All outputs are registered.

Test Plan:
- Load 2 words, bytes 13 05 A0 00 93 05 B0 00, run_limit=0 → mem_we pulses twice: (addr 0, 0x00A00513) then (addr 1, 0x00B00593); core_reset_n rises 2 cycles after the second mem_we.
- rx_valid toggled 1-0-1 per byte during load → only handshaked bytes are used; words match the no-gap case; rx_ready=0 during WRITE.
- RUN with halt_req asserted in the 7th RUN cycle → done pulses once, status=01, cycle_count=7, core_en=0, core_reset_n=1.
- run_limit=5, halt_req never asserted → exactly 5 cycles with core_en=1, status=10, cycle_count=5; halt_req on the 5th cycle instead → status=01.
- From HALT, load_start with load_len=0 → no mem_we, RELEASE then RUN, cycle_count restarts at 0.
- Assert reset=0 after 2 bytes of a word, then reload 1 word DE AD BE EF → single write of 0xEFBEADDE at addr 0; all outputs at reset values while reset=0.

Source files
------------

// File: rtl/core_boot_ctrl.sv
// Boot/run sequencer: holds the core in reset, streams host bytes into instruction
// memory as little-endian words, then releases the core and counts its run cycles.
module core_boot_ctrl #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [CNT_W-1:0]  run_limit,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              halt_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset_n,
  output logic              core_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_RELEASE, S_RUN, S_HALT
  } state_e;

  localparam logic [ADDR_W:0] MaxWords = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     wordIdx_q, wordIdx_d;
  logic [1:0]          byteIdx_q, byteIdx_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [CNT_W-1:0]    limit_q, limit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          status_q, status_d;

  logic                rxReady_q, memWe_q, coreResetN_q, coreEn_q, busy_q, done_q;
  logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
  logic [31:0]         memWdata_q, memWdata_d;

  logic [ADDR_W:0]     wordIdxInc;
  logic [CNT_W-1:0]    cntInc;
  logic [ADDR_W:0]     lenClip;

  assign wordIdxInc = wordIdx_q + 1'b1;
  assign cntInc     = cnt_q + 1'b1;
  assign lenClip    = (load_len > MaxWords) ? MaxWords : load_len;

  always_comb begin
    state_d   = state_q;
    wordIdx_d = wordIdx_q;
    byteIdx_d = byteIdx_q;
    word_d    = word_q;
    len_d     = len_q;
    limit_d   = limit_q;
    cnt_d     = cnt_q;
    status_d  = status_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (load_start) begin
          status_d  = 2'b00;
          cnt_d     = '0;
          limit_d   = run_limit;
          len_d     = lenClip;
          wordIdx_d = '0;
          byteIdx_d = '0;
          state_d   = (load_len == '0) ? S_RELEASE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (rx_valid && rxReady_q) begin
          word_d[{byteIdx_q, 3'b000} +: 8] = rx_data;
          byteIdx_d = byteIdx_q + 1'b1;
          if (byteIdx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wordIdx_d = wordIdxInc;
        state_d   = (wordIdxInc == len_q) ? S_RELEASE : S_LOAD;
      end
      S_RELEASE: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // Saturate so an unlimited run never wraps the visible count.
        if (cnt_q != '1) cnt_d = cntInc;
        if (halt_req) begin
          status_d = 2'b01;
          state_d  = S_HALT;
        end else if ((limit_q != '0) && (cntInc == limit_q)) begin
          status_d = 2'b10;
          state_d  = S_HALT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    if (state_d == S_WRITE) begin
      memAddr_d  = wordIdx_q[ADDR_W-1:0];
      memWdata_d = word_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wordIdx_q    <= '0;
      byteIdx_q    <= '0;
      word_q       <= '0;
      len_q        <= '0;
      limit_q      <= '0;
      cnt_q        <= '0;
      status_q     <= 2'b00;
      rxReady_q    <= 1'b0;
      memWe_q      <= 1'b0;
      memAddr_q    <= '0;
      memWdata_q   <= '0;
      coreResetN_q <= 1'b0;
      coreEn_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wordIdx_q    <= wordIdx_d;
      byteIdx_q    <= byteIdx_d;
      word_q       <= word_d;
      len_q        <= len_d;
      limit_q      <= limit_d;
      cnt_q        <= cnt_d;
      status_q     <= status_d;
      rxReady_q    <= (state_d == S_LOAD);
      memWe_q      <= (state_d == S_WRITE);
      memAddr_q    <= memAddr_d;
      memWdata_q   <= memWdata_d;
      coreResetN_q <= (state_d == S_RUN) || (state_d == S_HALT);
      coreEn_q     <= (state_d == S_RUN);
      busy_q       <= (state_d == S_LOAD) || (state_d == S_WRITE) ||
                      (state_d == S_RELEASE) || (state_d == S_RUN);
      done_q       <= (state_d == S_HALT) && (state_q != S_HALT);
    end
  end

  assign rx_ready     = rxReady_q;
  assign mem_we       = memWe_q;
  assign mem_addr     = memAddr_q;
  assign mem_wdata    = memWdata_q;
  assign core_reset_n = coreResetN_q;
  assign core_en      = coreEn_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign status       = status_q;
  assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Bench for core_boot_ctrl: a load/run model tracked from accepted bytes and run
// cycles is compared with the DUT every cycle, plus literal checks from the test plan.
module tb_core_boot_ctrl;

  logic        clk, reset, load_start, rx_valid, rx_ready, halt_req;
  logic [10:0] load_len;
  logic [15:0] run_limit, cycle_count;
  logic [7:0]  rx_data;
  logic        mem_we, core_reset_n, core_en, busy, done;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  status;

  core_boot_ctrl #(.ADDR_W(10), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
    .run_limit(run_limit), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .halt_req(halt_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_reset_n(core_reset_n),
    .core_en(core_en), .busy(busy), .done(done), .status(status),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmpOn = 0;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phases tracked as flags, written words rebuilt from the accepted byte stream.
  bit          mLoading, mPendWrite, mPendRelease, mRunning, mHalted, mFirst;
  int          mBytes, mLen, mLimit, mCount, mStatus, k;
  logic [7:0]  mBuf[$];
  logic [9:0]  eAddr;
  logic [31:0] eData;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mLoading = 0; mPendWrite = 0; mPendRelease = 0; mRunning = 0; mHalted = 0;
      mFirst = 0; mBytes = 0; mBuf.delete(); mCount = 0; mStatus = 0;
      eAddr = '0; eData = '0;
    end else begin
      mFirst = 0;
      if (mPendWrite) begin
        mPendWrite = 0;
        if (mBytes / 4 == mLen) begin
          mLoading = 0;
          mPendRelease = 1;
        end
      end else if (mLoading) begin
        if (rx_valid) begin
          mBuf.push_back(rx_data);
          mBytes++;
          if (mBytes % 4 == 0) begin
            mPendWrite = 1;
            k = mBytes / 4 - 1;
            eAddr = 10'(k);
            eData = {mBuf[4*k+3], mBuf[4*k+2], mBuf[4*k+1], mBuf[4*k]};
          end
        end
      end else if (mPendRelease) begin
        mPendRelease = 0;
        mRunning = 1;
        mCount = 0;
      end else if (mRunning) begin
        if (mCount != 65535) mCount++;
        if (halt_req || (mLimit != 0 && mCount == mLimit)) begin
          mStatus = halt_req ? 1 : 2;
          mRunning = 0; mHalted = 1; mFirst = 1;
        end
      end else if (load_start) begin
        mStatus = 0; mCount = 0; mHalted = 0;
        mLimit = int'(run_limit);
        mLen = (load_len > 11'd1024) ? 1024 : int'(load_len);
        if (mLen == 0) mPendRelease = 1;
        else begin
          mLoading = 1; mBytes = 0; mBuf.delete();
        end
      end
    end
  end

  logic [9:0]  wAddr[$];
  logic [31:0] wData[$];

  always @(negedge clk) begin
    #1;
    if (cmpOn) begin
      checkOutput("rx_ready", 32'(rx_ready), 32'(mLoading && !mPendWrite));
      checkOutput("mem_we", 32'(mem_we), 32'(mPendWrite));
      checkOutput("core_reset_n", 32'(core_reset_n), 32'(mRunning || mHalted));
      checkOutput("core_en", 32'(core_en), 32'(mRunning));
      checkOutput("busy", 32'(busy), 32'(mLoading || mPendRelease || mRunning));
      checkOutput("done", 32'(done), 32'(mFirst));
      checkOutput("status", 32'(status), 32'(mStatus));
      checkOutput("cycle_count", 32'(cycle_count), 32'(mCount));
      if (!reset || mPendWrite) begin
        checkOutput("mem_addr", 32'(mem_addr), 32'(eAddr));
        checkOutput("mem_wdata", mem_wdata, eData);
      end
      if (reset && mem_we) begin
        wAddr.push_back(mem_addr);
        wData.push_back(mem_wdata);
      end
    end
  end

  logic [7:0] txq[$];

  task automatic startLoad(input int len, input int lim);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = 11'(len);
    run_limit  = 16'(lim);
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    bit rdy, ok;
    ok = 0;
    repeat (gap) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 50; t++) begin
      rdy = rx_ready;
      @(negedge clk);
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input int len, input int lim, input int gap);
    startLoad(len, lim);
    foreach (txq[i]) sendByte(txq[i], gap);
    rx_valid = 1'b0;
  endtask

  task automatic waitRun();
    bit ok;
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      if (core_en) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) checkOutput("run_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDone(output int enCycles);
    bit ok;
    ok = 0;
    enCycles = 0;
    for (int t = 0; t < 300; t++) begin
      if (done) begin
        ok = 1;
        break;
      end
      if (core_en) enCycles++;
      @(negedge clk);
    end
    if (!ok) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int en;
    logic [7:0] prog [8];
    logic [31:0] lastWord;
    prog = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    reset = 1'b1; load_start = 1'b0; load_len = '0; run_limit = '0;
    rx_data = '0; rx_valid = 1'b0; halt_req = 1'b0;
    #2 reset = 1'b0;
    #1 cmpOn = 1;
    repeat (2) @(negedge clk);
    checkOutput("reset_core_reset_n", 32'(core_reset_n), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    // Two words back to back, unlimited run, halt in the 7th run cycle.
    txq.delete();
    foreach (prog[i]) txq.push_back(prog[i]);
    applyStimulus(2, 0, 0);
    waitRun();
    repeat (6) @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    checkOutput("halt7_done", 32'(done), 32'd1);
    checkOutput("halt7_status", 32'(status), 32'd1);
    checkOutput("halt7_count", 32'(cycle_count), 32'd7);
    checkOutput("halt7_core_en", 32'(core_en), 32'd0);
    checkOutput("halt7_core_reset_n", 32'(core_reset_n), 32'd1);
    checkOutput("load1_nwrites", 32'(wAddr.size()), 32'd2);
    checkOutput("load1_addr0", 32'(wAddr[0]), 32'd0);
    checkOutput("load1_data0", wData[0], 32'h00A00513);
    checkOutput("load1_addr1", 32'(wAddr[1]), 32'd1);
    checkOutput("load1_data1", wData[1], 32'h00B00593);
    @(negedge clk);
    checkOutput("halt7_done_once", 32'(done), 32'd0);

    // Same program with rx_valid gaps, then a 5-cycle limit.
    applyStimulus(2, 5, 1);
    waitDone(en);
    checkOutput("limit5_en_cycles", 32'(en), 32'd5);
    checkOutput("limit5_status", 32'(status), 32'd2);
    checkOutput("limit5_count", 32'(cycle_count), 32'd5);
    checkOutput("gap_data0", wData[2], 32'h00A00513);
    checkOutput("gap_data1", wData[3], 32'h00B00593);

    // Zero-length load reruns the program; halt on the limit cycle wins.
    startLoad(0, 5);
    waitRun();
    checkOutput("rerun_count_start", 32'(cycle_count), 32'd0);
    load_start = 1'b1;
    load_len = 11'd3;
    @(negedge clk);
    load_start = 1'b0;
    repeat (3) @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    checkOutput("rerun_status", 32'(status), 32'd1);
    checkOutput("rerun_count", 32'(cycle_count), 32'd5);
    checkOutput("rerun_nwrites", 32'(wAddr.size()), 32'd4);

    // Reset part-way through a word, then reload a single word.
    startLoad(1, 3);
    sendByte(8'h11, 0);
    sendByte(8'h22, 0);
    rx_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midreset_status", 32'(status), 32'd0);
    checkOutput("midreset_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("midreset_wdata", mem_wdata, 32'd0);
    reset = 1'b1;
    txq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    applyStimulus(1, 3, 0);
    waitDone(en);
    checkOutput("reload_nwrites", 32'(wAddr.size()), 32'd5);
    checkOutput("reload_addr", 32'(wAddr[4]), 32'd0);
    checkOutput("reload_data", wData[4], 32'hEFBEADDE);
    checkOutput("reload_en_cycles", 32'(en), 32'd3);

    // Oversized length is clipped to the full 1024-word memory.
    txq.delete();
    for (int i = 0; i < 4096; i++) txq.push_back(8'($urandom_range(0, 255)));
    lastWord = {txq[4095], txq[4094], txq[4093], txq[4092]};
    applyStimulus(1500, 2, 0);
    waitDone(en);
    checkOutput("clip_nwrites", 32'(wAddr.size()), 32'd1029);
    checkOutput("clip_last_addr", 32'(wAddr[wAddr.size()-1]), 32'd1023);
    checkOutput("clip_last_data", wData[wData.size()-1], lastWord);
    checkOutput("clip_status", 32'(status), 32'd2);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
